// File: rtl/fixed_round_pipe.sv
// fixed_round_pipe
// Multi-lane pipelined fixed-point requantiser. It converts each signed
// IN_WIDTH.IN_FRAC_WIDTH lane to a signed OUT_WIDTH.OUT_FRAC_WIDTH lane.
// The rounding mode is selected at run time and is captured with each beat.
// Every lane saturates independently and reports when it does.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   mode            0 truncate, 1 half-up, 2 half-even, 3 stochastic
//   sat_clear       synchronous clear of sat_count (wins over an increment)
//   data_in         LANES x IN_WIDTH lanes, lane i at [i*IN_WIDTH +: IN_WIDTH]
//   data_in_valid / data_in_ready     input handshake
//   data_out        LANES x OUT_WIDTH lanes
//   data_out_valid / data_out_ready   output handshake
//   sat_flag        per-lane clamp indicator, aligned with data_out
//   sat_count       saturating count of output beats with any lane clamped
module fixed_round_pipe #(
  parameter int          LANES          = 4,
  parameter int          IN_WIDTH       = 8,
  parameter int          IN_FRAC_WIDTH  = 4,
  parameter int          OUT_WIDTH      = 4,
  parameter int          OUT_FRAC_WIDTH = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       sat_clear,
  input  logic [LANES*IN_WIDTH-1:0]  data_in,
  input  logic                       data_in_valid,
  output logic                       data_in_ready,
  output logic [LANES*OUT_WIDTH-1:0] data_out,
  output logic                       data_out_valid,
  input  logic                       data_out_ready,
  output logic [LANES-1:0]           sat_flag,
  output logic [15:0]                sat_count
);

  localparam int D    = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int SH   = (D > 0) ? 0 : -D;
  // One guard bit above the input so the rounding add can never wrap.
  localparam int TW   = IN_WIDTH + 1 + SH;
  localparam int DI   = (D > 0) ? D : 1;
  localparam int HALF = 1 << (DI - 1);

  localparam logic signed [TW-1:0] OMAX = TW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [TW-1:0] OMIN = TW'(-(2 ** (OUT_WIDTH - 1)));

  logic                 r_s1_valid;
  logic signed [TW-1:0] r_s1_t [LANES];
  logic                 r_s2_valid;
  logic [LANES*OUT_WIDTH-1:0] r_data_out;
  logic [LANES-1:0]     r_sat_flag;
  logic [15:0]          r_sat_count;
  logic [15:0]          r_lfsr;

  logic                 w_en1;
  logic                 w_en2;
  logic                 w_accept;
  logic                 w_out_hs;
  logic                 w_lfsr_fb;
  logic signed [TW-1:0] w_t [LANES];
  logic [LANES*OUT_WIDTH-1:0] w_clamp;
  logic [LANES-1:0]     w_sat;

  assign w_en2         = !r_s2_valid || data_out_ready;
  assign w_en1         = !r_s1_valid || w_en2;
  assign data_in_ready = w_en1;
  assign w_accept      = data_in_valid && w_en1;
  assign w_out_hs      = r_s2_valid && data_out_ready;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [IN_WIDTH-1:0] w_x;
    logic signed [TW-1:0]       w_xe;

    assign w_x  = data_in[i*IN_WIDTH +: IN_WIDTH];
    assign w_xe = {{(TW-IN_WIDTH){w_x[IN_WIDTH-1]}}, w_x};

    if (D > 0) begin : g_rnd
      logic [D-1:0]         w_rb;
      logic signed [TW-1:0] w_inc;

      // Low D bits of the LFSR rotated left by 4*i, picked directly.
      for (genvar j = 0; j < D; j++) begin : g_rb
        assign w_rb[j] = r_lfsr[(j + 16 - ((4 * i) % 16)) % 16];
      end

      always_comb begin
        w_inc = '0;
        case (mode)
          2'd0: w_inc = '0;
          2'd1: w_inc = TW'(HALF);
          // Bit D of x is the LSB that survives the shift; adding it breaks ties to even.
          2'd2: w_inc = TW'(HALF - 1) + {{(TW-1){1'b0}}, w_x[D]};
          2'd3: w_inc = {{(TW-D){1'b0}}, w_rb};
          default: w_inc = '0;
        endcase
      end

      assign w_t[i] = (w_xe + w_inc) >>> D;
    end else begin : g_shl
      assign w_t[i] = w_xe <<< SH;
    end

    assign w_sat[i] = (r_s1_t[i] > OMAX) || (r_s1_t[i] < OMIN);
    assign w_clamp[i*OUT_WIDTH +: OUT_WIDTH] =
        (r_s1_t[i] > OMAX) ? OMAX[OUT_WIDTH-1:0] :
        (r_s1_t[i] < OMIN) ? OMIN[OUT_WIDTH-1:0] :
                             r_s1_t[i][OUT_WIDTH-1:0];
  end

  // Stage 1: round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) r_s1_t[i] <= '0;
    end else if (w_en1) begin
      r_s1_valid <= data_in_valid;
      if (data_in_valid) r_s1_t <= w_t;
    end
  end

  // Stage 2: clamp. Output registers only change when the stage advances,
  // so data_out and sat_flag hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_data_out <= '0;
      r_sat_flag <= '0;
    end else if (w_en2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data_out <= w_clamp;
        r_sat_flag <= w_sat;
      end
    end
  end

  // The current value is used by the beat being accepted; the step follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_accept) begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (sat_clear) begin
      r_sat_count <= '0;
    end else if (w_out_hs && (|r_sat_flag) && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_s2_valid;
  assign sat_flag       = r_sat_flag;
  assign sat_count      = r_sat_count;

endmodule

// File: tb/tb_fixed_round_pipe.sv
// Testbench for fixed_round_pipe with default parameters (D = 2, 4 lanes).
module tb_fixed_round_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        sat_clear;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic [3:0]  sat_flag;
  logic [15:0] sat_count;

  fixed_round_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .sat_clear      (sat_clear),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .sat_flag       (sat_flag),
    .sat_count      (sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] din;
    logic [15:0] dout;
    logic [3:0]  sat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard state, all updated at the falling edge.
  logic        sb_en = 1'b0;
  logic        sb_kind = 1'b0;
  logic [15:0] cur_exp = '0;
  logic [19:0] sb_q [$];
  logic [15:0] m_lfsr = 16'hACE1;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_out = '0;
  logic [3:0]  prev_sat = '0;
  logic        exp_rdy;
  logic [19:0] sb_e;
  int          pops = 0;
  int          stoch_pass = 0;
  int          stoch_n = 0;
  int          stoch_sum = 0;
  int          stoch_bad = 0;
  int          stoch_mism = 0;
  logic [15:0] stoch_rec [1024];

  function automatic logic [15:0] stoch_exp(input logic [15:0] m);
    logic [1:0] inc [4];
    logic [15:0] r;
    inc[0] = m[1:0];
    inc[1] = m[13:12];
    inc[2] = m[9:8];
    inc[3] = m[5:4];
    r = '0;
    for (int l = 0; l < 4; l++) r[l*4 +: 4] = inc[l][1] ? 4'h2 : 4'h1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_lfsr = 16'hACE1;
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (sb_en) begin
        exp_rdy = (sb_q.size() < 2) || data_out_ready;
        chk("in_ready", data_in_ready, exp_rdy);
        if (stall_prev) begin
          chk("stall_valid", data_out_valid, 1'b1);
          chk("stall_data", data_out, prev_out);
          chk("stall_sat", sat_flag, prev_sat);
        end
        if (data_out_valid && data_out_ready) begin
          pops++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got beat %h expected none", data_out);
          end else begin
            sb_e = sb_q.pop_front();
            chk("sb_data", data_out, sb_e[15:0]);
            chk("sb_sat", sat_flag, sb_e[19:16]);
          end
          if (sb_kind) begin
            if (stoch_n < 1024) begin
              if (stoch_pass == 0) stoch_rec[stoch_n] = data_out;
              else if (stoch_rec[stoch_n] !== data_out) stoch_mism++;
            end
            for (int l = 0; l < 4; l++) begin
              stoch_sum += int'(data_out[l*4 +: 4]);
              if (data_out[l*4 +: 4] != 4'h1 && data_out[l*4 +: 4] != 4'h2) stoch_bad++;
            end
            stoch_n++;
          end
        end
        if (data_in_valid && data_in_ready)
          sb_q.push_back(sb_kind ? {4'h0, stoch_exp(m_lfsr)} : {4'h0, cur_exp});
      end
      if (data_in_valid && data_in_ready)
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      stall_prev = sb_en && data_out_valid && !data_out_ready;
      prev_out = data_out;
      prev_sat = sat_flag;
    end
  end

  task automatic apply_vec(input vec_t v, input int idx);
    int lat;
    bit seen;
    @(posedge clk); #1;
    mode = v.mode;
    data_in = v.din;
    data_in_valid = 1'b1;
    data_out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", idx), data_in_ready, 1'b1);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (data_out_valid) seen = 1;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 2);
    chk($sformatf("vec%0d_dout", idx), data_out, v.dout);
    chk($sformatf("vec%0d_sat", idx), sat_flag, v.sat);
    @(negedge clk);
    chk($sformatf("vec%0d_valid_drop", idx), data_out_valid, 1'b0);
    if (v.sat != 4'h0 && exp_cnt < 65535) exp_cnt++;
    chk($sformatf("vec%0d_sat_count", idx), sat_count, exp_cnt);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    data_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    int k;
    int cyc;
    bit acc;
    int lat;
    bit seen;

    vecs[0]  = '{2'd0, 32'hF60E0305, 16'hD301, 4'b0000};
    vecs[1]  = '{2'd0, 32'hF60E0306, 16'hD301, 4'b0000};
    vecs[2]  = '{2'd0, 32'hF60E030A, 16'hD302, 4'b0000};
    vecs[3]  = '{2'd0, 32'hF60E03FA, 16'hD30E, 4'b0000};
    vecs[4]  = '{2'd1, 32'hF60E0305, 16'hE411, 4'b0000};
    vecs[5]  = '{2'd1, 32'hF60E0306, 16'hE412, 4'b0000};
    vecs[6]  = '{2'd1, 32'hF60E030A, 16'hE413, 4'b0000};
    vecs[7]  = '{2'd1, 32'hF60E03FA, 16'hE41F, 4'b0000};
    vecs[8]  = '{2'd2, 32'hF60E0305, 16'hE411, 4'b0000};
    vecs[9]  = '{2'd2, 32'hF60E0306, 16'hE412, 4'b0000};
    vecs[10] = '{2'd2, 32'hF60E030A, 16'hE412, 4'b0000};
    vecs[11] = '{2'd2, 32'hF60E03FA, 16'hE41E, 4'b0000};
    vecs[12] = '{2'd1, 32'h001C807F, 16'h0787, 4'b0011};
    vecs[13] = '{2'd0, 32'h20E07C81, 16'h7878, 4'b1011};

    rst = 1'b1;
    mode = 2'd0;
    sat_clear = 1'b0;
    data_in = '0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", data_out_valid, 1'b0);
    chk("rst_data", data_out, 16'h0);
    chk("rst_sat", sat_flag, 4'h0);
    chk("rst_count", sat_count, 16'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Rounding modes and saturation
    for (int i = 0; i < 14; i++) apply_vec(vecs[i], i);

    // Mode change with beats in flight
    @(posedge clk); #1;
    data_out_ready = 1'b1;
    mode = 2'd0; data_in = 32'h06060606; data_in_valid = 1'b1;
    @(posedge clk); #1;
    mode = 2'd1;
    @(posedge clk); #1;
    data_in_valid = 1'b0; mode = 2'd2;
    lat = 0; seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (data_out_valid) seen = 1;
    end
    chk("modechg_first", data_out, 16'h1111);
    @(negedge clk);
    chk("modechg_second_valid", data_out_valid, 1'b1);
    chk("modechg_second", data_out, 16'h2222);
    repeat (3) @(posedge clk);

    // Backpressure stream
    @(posedge clk); #1;
    pops = 0; sb_kind = 1'b0; sb_en = 1'b1; mode = 2'd0;
    k = 0; cyc = 0; acc = 0;
    while ((k < 8 || pops < 8) && cyc < 300) begin
      if (acc) k++;
      data_in_valid = (k < 8);
      for (int l = 0; l < 4; l++) begin
        data_in[l*8 +: 8] = 8'(4 * (k - l));
        cur_exp[l*4 +: 4] = 4'(k - l);
      end
      data_out_ready = (cyc % 3 == 0);
      cyc++;
      @(negedge clk);
      acc = data_in_valid && data_in_ready;
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    sb_en = 1'b0;
    chk("bp_beats_out", pops, 8);
    chk("bp_queue_empty", sb_q.size(), 0);

    // Stochastic rounding, two passes from reset
    for (int p = 0; p < 2; p++) begin
      do_reset();
      stoch_pass = p; stoch_n = 0; stoch_sum = 0; stoch_bad = 0; stoch_mism = 0;
      sb_kind = 1'b1; sb_en = 1'b1;
      mode = 2'd3; data_in = 32'h06060606; data_out_ready = 1'b1;
      k = 0; cyc = 0; acc = 0;
      while ((k < 1024 || stoch_n < 1024) && cyc < 1200) begin
        if (acc) k++;
        data_in_valid = (k < 1024);
        cyc++;
        @(negedge clk);
        acc = data_in_valid && data_in_ready;
        @(posedge clk); #1;
      end
      data_in_valid = 1'b0;
      sb_en = 1'b0;
      chk($sformatf("stoch%0d_beats", p), stoch_n, 1024);
      chk($sformatf("stoch%0d_out_of_set", p), stoch_bad, 0);
      if (p == 0) begin
        checks++;
        if (stoch_sum * 100 < 145 * 4096 || stoch_sum * 100 > 155 * 4096) begin
          errors++;
          $display("FAIL stoch_mean: sum %0d over 4096 lanes, required 5940..6348", stoch_sum);
        end
      end else begin
        chk("stoch_repeat", stoch_mism, 0);
      end
    end
    sb_kind = 1'b0;

    // Reset with both stages full
    do_reset();
    @(posedge clk); #1;
    data_out_ready = 1'b0; mode = 2'd0;
    data_in = 32'h10101010; data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in = 32'h20202020;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", data_in_ready, 1'b0);
    chk("full_out_valid", data_out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", data_out_valid, 1'b0);
    chk("midrst_data", data_out, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
    data_out_ready = 1'b1;
    data_in = 32'h1CF40804; data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (data_out_valid) seen = 1;
    end
    chk("midrst_first_beat", data_out, 16'h7D21);
    chk("midrst_first_lat", lat, 2);
    repeat (2) @(posedge clk);

    // Saturating counter
    @(posedge clk); #1;
    data_out_ready = 1'b1; mode = 2'd0;
    data_in = 32'h7F7F7F7F; data_in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1 data_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("cnt_saturated", sat_count, 16'hFFFF);
    @(posedge clk); #1;
    data_out_ready = 1'b0;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (data_out_valid) seen = 1;
    end
    chk("cnt_clear_beat_valid", data_out_valid, 1'b1);
    @(posedge clk); #1;
    data_out_ready = 1'b1; sat_clear = 1'b1;
    @(negedge clk);
    chk("cnt_hold_before_clear", sat_count, 16'hFFFF);
    @(posedge clk); #1;
    sat_clear = 1'b0;
    @(negedge clk);
    chk("cnt_clear_wins", sat_count, 16'h0);
    exp_cnt = 0;
    apply_vec(vecs[12], 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
